i2c_rw_arbiter: RTL and testbench

I2C_RW_ARBITER -- requirements
Module: i2c_rw_arbiter

---
 rtl/i2c_arb_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 26 ++
 rtl/i2c_rw_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_i2c_rw_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the two-requester I2C EEPROM read/write arbiter.
// Holds the FSM state encoding, the default timing parameters and a helper
// that turns a cycle count into the terminal value of the shared counter.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GAP      = 2'd1,
    ST_WAIT_END = 2'd2,
    ST_WR_WAIT  = 2'd3
  } arb_state_e;

  localparam int unsigned START_GAP_DEF     = 16;
  localparam int unsigned WR_CYCLE_WAIT_DEF = 5000;
  localparam int unsigned TIMEOUT_DEF       = 65535;

  localparam int unsigned CNT_W = 16;

  // Terminal count for a phase lasting n cycles (counter runs 0 .. n-1).
  function automatic logic [CNT_W-1:0] last_count(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector.
// Ports:
//   req_i      - request vector, one bit per requester
//   en_i       - grant enable; no grant is reported while low
//   ptr_i      - preferred requester for a tie (the one not granted last)
//   gnt_idx_o  - index of the requester that wins
//   gnt_vld_o  - a grant is issued this cycle
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       ptr_i,
  output logic       gnt_idx_o,
  output logic       gnt_vld_o
);

  always_comb begin
    gnt_vld_o = en_i & (|req_i);
    // A lone request wins outright; only a tie consults the pointer.
    if (req_i == 2'b11) begin
      gnt_idx_o = ptr_i;
    end else begin
      gnt_idx_o = req_i[1];
    end
  end

endmodule

// File: rtl/i2c_rw_arbiter.sv
// Arbitrates two requesters onto one I2C EEPROM controller.
// A granted transaction waits START_GAP cycles, pulses i2c_start, then waits
// for i2c_end (or aborts after TIMEOUT cycles). Writes are followed by an
// EEPROM write-cycle hold-off of WR_CYCLE_WAIT cycles before the next grant.
// Ports:
//   i2c_clk, sys_rst        - clock, asynchronous active-high reset
//   req, req_wr             - per-requester request and direction (1 = write)
//   req_addr, req_wdata     - per-requester address [16 each] and write byte
//   ack, err, rdata         - completion pulse, timeout flag, read byte
//   busy                    - arbiter not idle
//   wr_en, rd_en, i2c_start - controls to the I2C controller
//   byte_addr, wr_data      - latched transaction fields
//   i2c_end, rd_data        - controller completion pulse and read byte
module i2c_rw_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned START_GAP     = START_GAP_DEF,
  parameter int unsigned WR_CYCLE_WAIT = WR_CYCLE_WAIT_DEF,
  parameter int unsigned TIMEOUT       = TIMEOUT_DEF
) (
  input  logic        i2c_clk,
  input  logic        sys_rst,
  input  logic [1:0]  req,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  ack,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        wr_en,
  output logic        rd_en,
  output logic        i2c_start,
  output logic [15:0] byte_addr,
  output logic [7:0]  wr_data,
  input  logic        i2c_end,
  input  logic [7:0]  rd_data
);

  localparam logic [CNT_W-1:0] GAP_LAST = last_count(START_GAP);
  localparam logic [CNT_W-1:0] WRW_LAST = last_count(WR_CYCLE_WAIT);
  localparam logic [CNT_W-1:0] TO_LAST  = last_count(TIMEOUT);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             gidx_q, gidx_d;
  logic [15:0]      byte_addr_q, byte_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             wr_en_q, wr_en_d;
  logic             rd_en_q, rd_en_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [1:0]       ack_q, ack_d;
  logic             err_q, err_d;
  logic             start_q, start_d;

  logic             idle;
  logic             gnt_idx;
  logic             gnt_vld;

  assign idle = (state_q == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .req_i     (req),
    .en_i      (idle),
    .ptr_i     (ptr_q),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_ff @(posedge i2c_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      gidx_q      <= 1'b0;
      byte_addr_q <= 16'h0000;
      wr_data_q   <= 8'h00;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rdata_q     <= 8'h00;
      ack_q       <= 2'b00;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      byte_addr_q <= byte_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      start_q     <= start_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    byte_addr_d = byte_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = wr_en_q;
    rd_en_d     = rd_en_q;
    rdata_d     = rdata_q;
    ack_d       = 2'b00;
    err_d       = 1'b0;
    start_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          gidx_d      = gnt_idx;
          // Favour the other requester on the next tie.
          ptr_d       = ~gnt_idx;
          byte_addr_d = gnt_idx ? req_addr[31:16] : req_addr[15:0];
          wr_data_d   = gnt_idx ? req_wdata[15:8] : req_wdata[7:0];
          wr_en_d     = req_wr[gnt_idx];
          rd_en_d     = ~req_wr[gnt_idx];
          cnt_d       = '0;
          state_d     = ST_GAP;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT_END;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT_END: begin
        // Completion is checked first so it wins over a coincident timeout.
        if (i2c_end) begin
          ack_d[gidx_q] = 1'b1;
          wr_en_d       = 1'b0;
          rd_en_d       = 1'b0;
          cnt_d         = '0;
          if (rd_en_q) begin
            rdata_d = rd_data;
          end
          state_d = wr_en_q ? ST_WR_WAIT : ST_IDLE;
        end else if (cnt_q == TO_LAST) begin
          ack_d[gidx_q] = 1'b1;
          err_d         = 1'b1;
          wr_en_d       = 1'b0;
          rd_en_d       = 1'b0;
          cnt_d         = '0;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WR_WAIT: begin
        if (cnt_q == WRW_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = ~idle;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign i2c_start = start_q;
  assign byte_addr = byte_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_rw_arbiter.sv
module tb_i2c_rw_arbiter;

  logic        i2c_clk = 1'b0;
  logic        sys_rst;
  logic [1:0]  req;
  logic [1:0]  req_wr;
  logic [31:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  ack;
  logic        err;
  logic [7:0]  rdata;
  logic        busy;
  logic        wr_en;
  logic        rd_en;
  logic        i2c_start;
  logic [15:0] byte_addr;
  logic [7:0]  wr_data;
  logic        i2c_end;
  logic [7:0]  rd_data;

  int n_checks    = 0;
  int n_errors    = 0;
  int acks_seen   = 0;
  int acks_popped = 0;

  typedef struct {
    logic [1:0] ack;
    logic       err;
    logic [7:0] rdata;
    logic       chk_rd;
  } exp_t;

  exp_t sb[$];

  logic [7:0] alt_vals [4];

  i2c_rw_arbiter dut (
    .i2c_clk   (i2c_clk),
    .sys_rst   (sys_rst),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .i2c_start (i2c_start),
    .byte_addr (byte_addr),
    .wr_data   (wr_data),
    .i2c_end   (i2c_end),
    .rd_data   (rd_data)
  );

  initial forever #5 i2c_clk = ~i2c_clk;

  always @(negedge i2c_clk) begin
    if (ack != 2'b00) acks_seen++;
  end

  task automatic tick();
    @(posedge i2c_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] a, input logic e, input logic [7:0] r, input logic c);
    exp_t x;
    x.ack    = a;
    x.err    = e;
    x.rdata  = r;
    x.chk_rd = c;
    sb.push_back(x);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},      32'(busy),      32'h0);
    chk({tag, "_wr_en"},     32'(wr_en),     32'h0);
    chk({tag, "_rd_en"},     32'(rd_en),     32'h0);
    chk({tag, "_start"},     32'(i2c_start), 32'h0);
    chk({tag, "_ack"},       32'(ack),       32'h0);
    chk({tag, "_err"},       32'(err),       32'h0);
    chk({tag, "_byte_addr"}, 32'(byte_addr), 32'h0);
    chk({tag, "_wr_data"},   32'(wr_data),   32'h0);
    chk({tag, "_rdata"},     32'(rdata),     32'h0);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (i2c_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("start_seen", 32'(i2c_start), 32'h1);
  endtask

  task automatic expect_ack(input string tag, input int budget, output int waited);
    exp_t e;
    waited = 0;
    while (ack === 2'b00 && waited < budget) begin
      tick();
      waited++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_underflow"}, sb.size(), 32'h1);
      return;
    end
    e = sb.pop_front();
    acks_popped++;
    chk({tag, "_ack"}, 32'(ack), 32'(e.ack));
    chk({tag, "_err"}, 32'(err), 32'(e.err));
    if (e.chk_rd) chk({tag, "_rdata"}, 32'(rdata), 32'(e.rdata));
  endtask

  initial begin
    int n;
    int w;
    int bc;

    alt_vals = '{8'h10, 8'h21, 8'h12, 8'h23};

    sys_rst   = 1'b1;
    req       = 2'b00;
    req_wr    = 2'b00;
    req_addr  = 32'h0;
    req_wdata = 16'h0;
    i2c_end   = 1'b0;
    rd_data   = 8'h00;

    // reset values
    repeat (3) tick();
    chk_reset("rst");
    sys_rst = 1'b0;
    tick();
    chk("rst_release_busy", 32'(busy), 32'h0);

    // stray end in IDLE
    i2c_end = 1'b1;
    tick();
    i2c_end = 1'b0;
    tick();
    chk("idle_stray_ack",  32'(ack),  32'h0);
    chk("idle_stray_busy", 32'(busy), 32'h0);

    // req0 write 0xA5 -> 0x005A
    req_addr[15:0]  = 16'h005A;
    req_wdata[7:0]  = 8'hA5;
    req_wr[0]       = 1'b1;
    req[0]          = 1'b1;
    push_exp(2'b01, 1'b0, 8'h00, 1'b0);
    tick();
    chk("wr_busy",      32'(busy),      32'h1);
    chk("wr_wr_en",     32'(wr_en),     32'h1);
    chk("wr_rd_en",     32'(rd_en),     32'h0);
    chk("wr_byte_addr", 32'(byte_addr), 32'h005A);
    chk("wr_wr_data",   32'(wr_data),   32'hA5);
    req_addr[15:0] = 16'hFFFF;
    req_wdata[7:0] = 8'hFF;
    i2c_end = 1'b1;
    tick();
    i2c_end = 1'b0;
    chk("gap_stray_ack",  32'(ack),  32'h0);
    chk("gap_stray_busy", 32'(busy), 32'h1);
    wait_start(n);
    chk("wr_start_latency",   2 + n, 32'd17);
    chk("wr_fields_held_a",   32'(byte_addr), 32'h005A);
    chk("wr_fields_held_d",   32'(wr_data),   32'hA5);
    i2c_end = 1'b1;
    tick();
    i2c_end = 1'b0;
    chk("start_one_cycle", 32'(i2c_start), 32'h0);
    expect_ack("wr", 2, w);
    chk("wr_en_drop",   32'(wr_en), 32'h0);
    chk("wr_wait_busy", 32'(busy),  32'h1);

    // req1 read raised during the write-cycle hold-off
    req[0]           = 1'b0;
    req_addr[15:0]   = 16'h005A;
    req_wr[1]        = 1'b0;
    req_addr[31:16]  = 16'h005A;
    req[1]           = 1'b1;
    push_exp(2'b10, 1'b0, 8'h3C, 1'b1);
    bc = 0;
    while (busy === 1'b1 && bc < 6000) begin
      bc++;
      i2c_end = (bc == 100);
      tick();
    end
    i2c_end = 1'b0;
    chk("wr_wait_len",  bc,       32'd5000);
    chk("holdoff_ack", 32'(ack), 32'h0);
    tick();
    chk("rd_busy",      32'(busy),      32'h1);
    chk("rd_rd_en",     32'(rd_en),     32'h1);
    chk("rd_wr_en",     32'(wr_en),     32'h0);
    chk("rd_byte_addr", 32'(byte_addr), 32'h005A);
    wait_start(n);
    chk("rd_start_latency", 1 + n, 32'd17);
    rd_data = 8'h3C;
    i2c_end = 1'b1;
    tick();
    i2c_end = 1'b0;
    rd_data = 8'hEE;
    req[1]  = 1'b0;
    expect_ack("rd", 2, w);
    chk("rd_ack_latency", w,               32'd0);
    chk("rd_idle",        32'(busy),       32'h0);
    chk("rd_en_drop",     32'(rd_en),      32'h0);
    chk("rd_addr_hold",   32'(byte_addr),  32'h005A);
    tick();
    chk("rdata_hold", 32'(rdata), 32'h3C);
    chk("rd_ack_once", 32'(ack), 32'h0);

    // timeout on req0 read
    req_wr[0]      = 1'b0;
    req_addr[15:0] = 16'h0123;
    req[0]         = 1'b1;
    push_exp(2'b01, 1'b1, 8'h3C, 1'b1);
    wait_start(n);
    chk("to_start_latency", n, 32'd17);
    expect_ack("timeout", 70000, w);
    req[0] = 1'b0;
    chk("timeout_cycles", w,           32'd65535);
    chk("timeout_rd_en",  32'(rd_en),  32'h0);
    tick();
    chk("timeout_idle",   32'(busy),   32'h0);

    // reset during WR_WAIT
    req_wr[1]       = 1'b1;
    req_addr[31:16] = 16'h0100;
    req_wdata[15:8] = 8'h42;
    req[1]          = 1'b1;
    push_exp(2'b10, 1'b0, 8'h00, 1'b0);
    wait_start(n);
    i2c_end = 1'b1;
    tick();
    i2c_end = 1'b0;
    expect_ack("wr1", 2, w);
    req[1] = 1'b0;
    repeat (50) tick();
    chk("wrw_busy",      32'(busy),      32'h1);
    chk("wrw_byte_addr", 32'(byte_addr), 32'h0100);
    chk("wrw_wr_data",   32'(wr_data),   32'h42);
    #2 sys_rst = 1'b1;
    #1 chk_reset("rst_wrwait");
    tick();
    tick();
    sys_rst = 1'b0;
    repeat (20) tick();
    chk("post_rst1_busy", 32'(busy), 32'h0);

    // reset during WAIT_END
    req_wr[0]      = 1'b0;
    req_addr[15:0] = 16'h0BCD;
    req[0]         = 1'b1;
    wait_start(n);
    repeat (10) tick();
    chk("we_rd_en", 32'(rd_en), 32'h1);
    chk("we_busy",  32'(busy),  32'h1);
    #2 sys_rst = 1'b1;
    #1 chk_reset("rst_waitend");
    req[0] = 1'b0;
    tick();
    sys_rst = 1'b0;
    i2c_end = 1'b1;
    tick();
    i2c_end = 1'b0;
    repeat (20) tick();
    chk("post_rst2_busy", 32'(busy), 32'h0);

    // re-request after reset
    req[0] = 1'b1;
    push_exp(2'b01, 1'b0, 8'h77, 1'b1);
    wait_start(n);
    chk("rereq_addr", 32'(byte_addr), 32'h0BCD);
    rd_data = 8'h77;
    i2c_end = 1'b1;
    tick();
    i2c_end = 1'b0;
    req[0]  = 1'b0;
    expect_ack("rereq", 2, w);

    // both requests held from reset: grants alternate 0,1,0,1
    tick();
    sys_rst  = 1'b1;
    req_wr   = 2'b00;
    req_addr = {16'h2222, 16'h1111};
    req      = 2'b11;
    push_exp(2'b01, 1'b0, 8'h10, 1'b1);
    push_exp(2'b10, 1'b0, 8'h21, 1'b1);
    push_exp(2'b01, 1'b0, 8'h12, 1'b1);
    push_exp(2'b10, 1'b0, 8'h23, 1'b1);
    tick();
    sys_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_start(n);
      chk("alt_latency", n, 32'd17);
      chk("alt_addr", 32'(byte_addr), (k % 2 == 1) ? 32'h2222 : 32'h1111);
      rd_data = alt_vals[k];
      i2c_end = 1'b1;
      tick();
      i2c_end = 1'b0;
      if (k == 3) req = 2'b00;
      expect_ack("alt", 2, w);
    end
    tick();
    chk("alt_idle", 32'(busy), 32'h0);
    tick();

    chk("sb_empty",  sb.size(), 32'd0);
    chk("ack_count", acks_seen, acks_popped);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
